// File: rtl/timer_pkg.sv
// Shared definitions for the mm:ss timer core: FSM encoding, BCD digit limits
// and the preset digit check.
package timer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   localparam logic [3:0] BCD_MAX_UNITS    = 4'd9;
   localparam logic [3:0] BCD_MAX_TENS_SEC = 4'd5;

   function automatic logic bcd_digit_valid(input logic [3:0] digit, input logic [3:0] max_val);
      return (digit <= max_val);
   endfunction

endpackage

// File: rtl/mmss_timer_core_bcd_digit.sv
// Single BCD digit counting 0..MAX up or down, with a load port and
// carry/borrow flags that let the parent ripple steps within one cycle.
module bcd_digit
   import timer_pkg::*;
#(
   parameter logic [3:0] MAX = BCD_MAX_UNITS
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       EN,
   input  logic       DIR,
   input  logic       LD,
   input  logic [3:0] LD_VAL,
   output logic [3:0] value,
   output logic       CARRY,
   output logic       BORROW
);

   logic [3:0] value_r;

   // Digit register: load has priority over a count step.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         value_r <= 4'd0;
      end else if (LD) begin
         value_r <= LD_VAL;
      end else if (EN) begin
         if (DIR) begin
            value_r <= (value_r == MAX) ? 4'd0 : value_r + 4'd1;
         end else begin
            value_r <= (value_r == 4'd0) ? MAX : value_r - 4'd1;
         end
      end
   end

   assign value  = value_r;
   assign CARRY  = DIR & (value_r == MAX);
   assign BORROW = ~DIR & (value_r == 4'd0);

endmodule

// File: rtl/mmss_timer_core.sv
// mm:ss up/down timer: run/pause/done FSM, validated BCD preset, stop-or-wrap
// terminal policy and tick prescaler. TIME_BCD is {minutes, sec tens, sec units}.
module mmss_timer_core
   import timer_pkg::*;
#(
   parameter int TICK_DIV   = 12000000,
   parameter int MIN_DIGITS = 2,
   parameter int WRAP_MODE  = 0
) (
   input  logic                      CLK,
   input  logic                      RESET,
   input  logic                      START,
   input  logic                      STOP,
   input  logic                      CLEAR,
   input  logic                      LOAD,
   input  logic                      DIR,
   input  logic [4*MIN_DIGITS-1:0]   LOAD_MIN,
   input  logic [7:0]                LOAD_SEC,
   output logic [4*MIN_DIGITS+7:0]   TIME_BCD,
   output logic [1:0]                STATE,
   output logic                      RUNNING,
   output logic                      DONE,
   output logic                      TICK,
   output logic                      WRAP,
   output logic                      LOAD_ERR
);

   localparam int             NDIG       = MIN_DIGITS + 2;
   localparam int             TW         = 4 * NDIG;
   localparam int             PW         = $clog2(TICK_DIV);
   localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_DIV - 1);
   localparam logic           WRAP_EN    = (WRAP_MODE != 0);

   state_e          state_r;
   logic [PW-1:0]   presc_r;
   logic            tick_r;
   logic            wrap_r;
   logic            load_err_r;

   logic [TW-1:0]   time_s;
   logic [TW-1:0]   load_val_s;
   logic [TW-1:0]   ld_val_s;
   logic [NDIG-1:0] en_s;
   logic [NDIG-1:0] carry_s;
   logic [NDIG-1:0] borrow_s;
   logic [NDIG-1:0] is_max_s;
   logic [NDIG-1:0] is_zero_s;
   logic [NDIG-1:0] valid_s;

   logic hi_zero_s, hi_max_s, term_down_s, term_up_s, near_down_s, near_up_s;
   logic load_valid_s, load_acc_s, load_ok_s, stop_s, start_s, tick_s;
   logic at_term_s, hold_s, step_s, reach_s, wrap_s, digit_ld_s;

   assign load_val_s = {LOAD_MIN, LOAD_SEC};

   // Digit 0 = seconds units, digit 1 = seconds tens, the rest are minutes.
   for (genvar i = 0; i < NDIG; i++) begin : g_digit
      localparam logic [3:0] DMAX = (i == 1) ? BCD_MAX_TENS_SEC : BCD_MAX_UNITS;

      bcd_digit #(.MAX(DMAX)) u_digit (
         .CLK    (CLK),
         .RESET  (RESET),
         .EN     (en_s[i]),
         .DIR    (DIR),
         .LD     (digit_ld_s),
         .LD_VAL (ld_val_s[4*i +: 4]),
         .value  (time_s[4*i +: 4]),
         .CARRY  (carry_s[i]),
         .BORROW (borrow_s[i])
      );

      assign is_max_s[i]  = (time_s[4*i +: 4] == DMAX);
      assign is_zero_s[i] = (time_s[4*i +: 4] == 4'd0);
      assign valid_s[i]   = bcd_digit_valid(load_val_s[4*i +: 4], DMAX);

      if (i == 0) begin : g_first
         assign en_s[i] = step_s;
      end else begin : g_ripple
         assign en_s[i] = en_s[i-1] & (carry_s[i-1] | borrow_s[i-1]);
      end
   end

   // One step away from a terminal: 00:01 going down, max-1 going up.
   assign hi_zero_s    = &is_zero_s[NDIG-1:1];
   assign hi_max_s     = &is_max_s[NDIG-1:1];
   assign term_down_s  = hi_zero_s & is_zero_s[0];
   assign term_up_s    = hi_max_s & is_max_s[0];
   assign near_down_s  = hi_zero_s & (time_s[3:0] == 4'd1);
   assign near_up_s    = hi_max_s & (time_s[3:0] == 4'd8);
   assign load_valid_s = &valid_s;

   // Command decode in priority order CLEAR > LOAD > STOP > START > tick.
   always_comb begin
      load_acc_s = 1'b0;
      load_ok_s  = 1'b0;
      stop_s     = 1'b0;
      start_s    = 1'b0;
      tick_s     = 1'b0;
      if (CLEAR) begin
         load_acc_s = 1'b0;
      end else if (LOAD && (state_r != ST_RUN)) begin
         load_acc_s = 1'b1;
         load_ok_s  = load_valid_s;
      end else if (STOP && (state_r == ST_RUN)) begin
         stop_s = 1'b1;
      end else if (START && (state_r == ST_PAUSE)) begin
         start_s = 1'b1;
      end else if (START && (state_r == ST_IDLE)) begin
         start_s = ~(~DIR & term_down_s & ~WRAP_EN);
      end else if (state_r == ST_RUN) begin
         tick_s = (presc_r == PRESC_LAST);
      end else begin
         tick_s = 1'b0;
      end
   end

   // Step qualification: stop mode refuses to step past a terminal value.
   always_comb begin
      at_term_s  = DIR ? term_up_s : term_down_s;
      hold_s     = tick_s & at_term_s & ~WRAP_EN;
      step_s     = tick_s & ~hold_s;
      reach_s    = tick_s & ~WRAP_EN & (DIR ? near_up_s : near_down_s);
      wrap_s     = tick_s & WRAP_EN & at_term_s;
      digit_ld_s = CLEAR | load_ok_s;
      if (CLEAR) begin
         ld_val_s = {TW{1'b0}};
      end else begin
         ld_val_s = load_val_s;
      end
   end

   // FSM, prescaler and registered pulse outputs.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_r    <= ST_IDLE;
         presc_r    <= {PW{1'b0}};
         tick_r     <= 1'b0;
         wrap_r     <= 1'b0;
         load_err_r <= 1'b0;
      end else begin
         tick_r     <= tick_s;
         wrap_r     <= wrap_s;
         load_err_r <= load_acc_s & ~load_valid_s;
         if (CLEAR) begin
            state_r <= ST_IDLE;
            presc_r <= {PW{1'b0}};
         end else if (load_acc_s) begin
            if (load_ok_s) begin
               presc_r <= {PW{1'b0}};
               state_r <= (state_r == ST_PAUSE) ? ST_PAUSE : ST_IDLE;
            end
         end else if (stop_s) begin
            state_r <= ST_PAUSE;
         end else if (start_s) begin
            if (state_r == ST_IDLE) begin
               presc_r <= {PW{1'b0}};
            end
            state_r <= ST_RUN;
         end else if (state_r == ST_RUN) begin
            if (tick_s) begin
               presc_r <= {PW{1'b0}};
               if (hold_s || reach_s) begin
                  state_r <= ST_DONE;
               end
            end else begin
               presc_r <= presc_r + PW'(1);
            end
         end
      end
   end

   assign TIME_BCD = time_s;
   assign STATE    = state_r;
   assign RUNNING  = (state_r == ST_RUN);
   assign DONE     = (state_r == ST_DONE);
   assign TICK     = tick_r;
   assign WRAP     = wrap_r;
   assign LOAD_ERR = load_err_r;

endmodule

// File: doc/mmss_timer_core.md
Name: mmss_timer_core

Overview:
Parametrised mm:ss up/down timer core that replaces the fixed counter chain in the display top level. It provides:
- a run/pause/done state machine,
- BCD preset loading with validation,
- a selectable stop-or-wrap policy at the terminal count,
- an internal tick prescaler.

Its packed BCD output feeds the existing display mux and seven-segment decoder unchanged.

Parameters:
- TICK_DIV, 12000000: CLK cycles per count step (1 s at 12 MHz); must be >= 2.
- MIN_DIGITS, 2: number of BCD minute digits; maximum time is all-nines:59.
- WRAP_MODE, 0: 0 = stop at terminal count and enter DONE; 1 = wrap and keep running.

Ports:
- CLK  in  1  system clock
- RESET  in  1  reset; asynchronous, active-low (0 = reset)
- START  in  1  single-cycle pulse: IDLE/PAUSE -> RUN
- STOP  in  1  single-cycle pulse: RUN -> PAUSE
- CLEAR  in  1  single-cycle pulse: any state -> IDLE, time 00:00
- LOAD  in  1  single-cycle pulse: latch LOAD_MIN/LOAD_SEC
- DIR  in  1  1 = count up, 0 = count down
- LOAD_MIN  in  4*MIN_DIGITS  preset minutes, BCD
- LOAD_SEC  in  8  preset seconds, BCD (tens, units)
- TIME_BCD  out  4*MIN_DIGITS+8  current time {minutes, sec tens, sec units}
- STATE  out  2  current FSM state
- RUNNING  out  1  high when STATE = RUN
- DONE  out  1  high when STATE = DONE
- TICK  out  1  one-cycle pulse on every count step
- WRAP  out  1  one-cycle pulse on wrap-around (WRAP_MODE = 1 only)
- LOAD_ERR  out  1  one-cycle pulse when a LOAD is rejected

Behaviour:
Reset
- RESET low immediately forces STATE=IDLE, TIME_BCD=0, prescaler=0, and all pulse outputs 0. This holds in any state, including mid-RUN.

FSM states: IDLE, RUN, PAUSE, DONE.
- IDLE -> RUN on START, except when DIR=0, time=00:00 and WRAP_MODE=0; in that case START is ignored.
- RUN -> PAUSE on STOP.
- PAUSE -> RUN on START.
- RUN -> DONE on the terminal-count edge (WRAP_MODE=0).
- DONE -> IDLE on LOAD (if valid) or CLEAR. START and STOP are ignored in DONE.
- Any state -> IDLE on CLEAR.

Priority when inputs coincide in one cycle: CLEAR > LOAD > STOP > START > tick.

Prescaler
- Counts 0..TICK_DIV-1 only while in RUN.
- On the edge where it wraps, TICK=1 for that one cycle and the time register updates on that same edge (registered; zero extra latency).
- Prescaler is held in PAUSE, so phase is preserved across pause/resume.
- Prescaler is cleared by START from IDLE, and by LOAD and CLEAR.

Counting
- Seconds units: 0..9. Seconds tens: 0..5. Each minute digit: 0..9.
- Carries and borrows ripple through the digits within the same cycle.
- DIR is sampled at each tick, so a direction change takes effect on the next step.

Terminal counts
- Down: 00:00. Up: max (all-nines:59).
- WRAP_MODE=0: the step that reaches the terminal value sets the time to it and STATE=DONE on the same edge.
- WRAP_MODE=1: a step taken from the terminal value wraps (00:00 -> max going down; max -> 00:00 going up), pulses WRAP, and stays in RUN.

Loading
- LOAD is accepted in IDLE, PAUSE and DONE. In RUN it is ignored, with no LOAD_ERR.
- A load is invalid if any BCD digit > 9 or seconds tens > 5. An invalid load pulses LOAD_ERR, leaves the time and state unchanged, and does not clear the prescaler.
- A valid load in PAUSE stays in PAUSE; from DONE or IDLE it goes to IDLE.

Outputs are registered, or decoded directly from STATE. There are no combinational paths from inputs to outputs.

Decomposition:
- Shared package timer_pkg:
  - state encodings IDLE=2'd0, RUN=2'd1, PAUSE=2'd2, DONE=2'd3;
  - BCD_MAX_UNITS=9, BCD_MAX_TENS_SEC=5;
  - a BCD-digit-valid function.
- One sub-module, bcd_digit: a single BCD digit with parameter MAX and inputs EN, DIR, LD, LD_VAL.
  - Outputs: value, plus combinational CARRY (at MAX and counting up) and BORROW (at 0 and counting down).
  - Instantiated MIN_DIGITS+2 times in a generate loop.

Test Plan:
All scenarios use TICK_DIV=4, MIN_DIGITS=2, WRAP_MODE=0 unless stated.
- Async reset: drop RESET low mid-RUN between clock edges -> TIME_BCD=0, STATE=IDLE and RUNNING=0 before the next CLK edge; no TICK pulse afterwards.
- Countdown to done: LOAD 00:03, DIR=0, START -> TICK every 4th cycle; TIME_BCD goes 00:02, 00:01, 00:00; DONE=1 on the edge reaching 00:00; a further START leaves STATE=DONE.
- Borrow/wrap:
  - LOAD 10:00, DIR=0, START -> 09:59 after the first tick.
  - WRAP_MODE=1, LOAD 99:59, DIR=1, START -> 00:00 after one tick; WRAP high exactly one cycle; STATE stays RUN.
- Invalid load: LOAD_SEC=8'h60 in IDLE -> LOAD_ERR high one cycle; TIME_BCD unchanged.
- Pause phase: STOP 2 cycles after a tick, wait 10 cycles, START -> next TICK exactly 2 cycles later; TIME_BCD frozen during PAUSE.
- Priority: CLEAR and valid LOAD 05:00 in the same cycle -> STATE=IDLE, TIME_BCD=00:00, no LOAD_ERR.
